// File: rtl/rv_pkg.sv
// Shared types and helpers for the round-robin valid/ready arbiter.
package rv_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Upper bound on requesters supported by the search helpers.
    localparam int MAX_REQ = 32;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

    function automatic int first_set(input logic [MAX_REQ-1:0] vec, input int n);
        int idx;
        idx = 0;
        for (int i = MAX_REQ - 1; i >= 0; i--) begin
            if (i < n && vec[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rv_skid_reg.sv
// One-entry skid stage: upstream ready is a flop, so m_rdy never reaches s_rdy combinationally.
module rv_skid_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         s_val,
    output logic         s_rdy,
    input  logic [W-1:0] s_data,
    output logic         m_val,
    input  logic         m_rdy,
    output logic [W-1:0] m_data
);

    logic         buf_valid;
    logic [W-1:0] buf_data;
    logic         store;

    assign store = s_val & s_rdy & ~m_rdy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_valid <= 1'b0;
            buf_data  <= '0;
            s_rdy     <= 1'b1;
        end else begin
            buf_valid <= buf_valid ? ~m_rdy : store;
            if (store) begin
                buf_data <= s_data;
            end
            s_rdy <= m_rdy | (~buf_valid & ~store);
        end
    end

    // While s_rdy is low the buffer holds the oldest beat and must drain first.
    assign m_val  = s_rdy ? s_val  : buf_valid;
    assign m_data = s_rdy ? s_data : buf_data;

endmodule

// File: rtl/rv_rr_arbiter.sv
// Packet-atomic round-robin arbiter sharing one valid/ready channel, with a skid output stage.
module rv_rr_arbiter
    import rv_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WD      = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    in_val,
    input  logic [NUM_REQ-1:0]    in_last,
    input  logic [NUM_REQ*WD-1:0] in_data,
    output logic [NUM_REQ-1:0]    in_rdy,
    output logic                  out_val,
    input  logic                  out_rdy,
    output logic [WD-1:0]         out_data,
    output logic                  out_last,
    output logic [IDW-1:0]        out_id
);

    localparam int PW = WD + 1 + IDW;

    state_t             state, state_nxt;
    logic [IDW-1:0]     ptr, ptr_nxt;
    logic [IDW-1:0]     gnt_id, gnt_nxt;
    logic [IDW-1:0]     winner;
    logic [MAX_REQ-1:0] rot;
    logic               stage_rdy;
    logic               sel_val, sel_last, g_val;
    logic [WD-1:0]      sel_data;
    logic [PW-1:0]      s_data, m_data;

    // Rotate requests so that bit 0 is the requester at ptr.
    always_comb begin
        logic [IDW-1:0] idx;
        rot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx    = IDW'((int'(ptr) + i) % NUM_REQ);
            rot[i] = in_val[idx];
        end
        winner = IDW'((int'(ptr) + first_set(rot, NUM_REQ)) % NUM_REQ);
    end

    always_comb begin
        sel_val  = 1'b0;
        sel_last = 1'b0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDW'(i) == gnt_id) begin
                sel_val  = in_val[i];
                sel_last = in_last[i];
                sel_data = in_data[i*WD +: WD];
            end
        end
    end

    assign g_val = (state == LOCKED) && sel_val;

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        gnt_nxt   = gnt_id;
        in_rdy    = '0;
        case (state)
            IDLE: begin
                if (|in_val) begin
                    gnt_nxt   = winner;
                    state_nxt = LOCKED;
                end
            end
            LOCKED: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    in_rdy[i] = stage_rdy && (IDW'(i) == gnt_id);
                end
                // Always return to IDLE after the last beat, even if it landed in the skid buffer.
                if (g_val && stage_rdy && sel_last) begin
                    state_nxt = IDLE;
                    ptr_nxt   = IDW'(rr_next(int'(gnt_id), NUM_REQ));
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            ptr    <= '0;
            gnt_id <= '0;
        end else begin
            state  <= state_nxt;
            ptr    <= ptr_nxt;
            gnt_id <= gnt_nxt;
        end
    end

    assign s_data = g_val ? {sel_data, sel_last, gnt_id} : '0;

    rv_skid_reg #(
        .W(PW)
    ) u_skid (
        .clk    (clk),
        .rst_n  (rst_n),
        .s_val  (g_val),
        .s_rdy  (stage_rdy),
        .s_data (s_data),
        .m_val  (out_val),
        .m_rdy  (out_rdy),
        .m_data (m_data)
    );

    assign {out_data, out_last, out_id} = m_data;

endmodule

// File: tb/tb_rv_rr_arbiter.sv
// Self-checking bench for rv_rr_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_rv_rr_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WD      = 4;
    localparam int IDW     = 2;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NUM_REQ-1:0]    in_val = '0;
    logic [NUM_REQ-1:0]    in_last = '0;
    logic [NUM_REQ*WD-1:0] in_data = '0;
    logic [NUM_REQ-1:0]    in_rdy;
    logic                  out_val;
    logic                  out_rdy = 1'b0;
    logic [WD-1:0]         out_data;
    logic                  out_last;
    logic [IDW-1:0]        out_id;

    always #5 clk = ~clk;

    rv_rr_arbiter #(
        .NUM_REQ(NUM_REQ),
        .WD     (WD),
        .IDW    (IDW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_val   (in_val),
        .in_last  (in_last),
        .in_data  (in_data),
        .in_rdy   (in_rdy),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .out_data (out_data),
        .out_last (out_last),
        .out_id   (out_id)
    );

    typedef struct {
        logic [WD-1:0] data;
        bit            last;
        int            gap;
    } beat_t;

    typedef struct {
        logic [WD-1:0] data;
        bit            last;
        int            id;
    } obeat_t;

    beat_t  pq[NUM_REQ][$];
    bit     pres[NUM_REQ];
    obeat_t sb[$];
    obeat_t log_q[$];
    int     log_cyc[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    bit rst_req    = 1'b1;
    bit rand_ordy  = 1'b0;
    bit ordy_fixed = 1'b1;

    // Reference model: owner of the channel (-1 when arbitrating), next search start,
    // whether the output stage accepts this cycle, and the beats parked in the stage.
    bit     model_ok = 1'b0;
    int     m_owner  = -1;
    int     m_ptr    = 0;
    bit     m_acc    = 1'b1;
    obeat_t m_q[$];
    int     cur_owner = -1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic addBeat(input int r, input int data, input bit last, input int gap);
        beat_t b;
        b.data = WD'(data);
        b.last = last;
        b.gap  = gap;
        pq[r].push_back(b);
    endtask

    task automatic addRandomPacket(input int r);
        int len;
        len = $urandom_range(1, 3);
        for (int k = 0; k < len; k++) begin
            addBeat(r, int'($urandom_range(15)), k == len - 1,
                    ($urandom_range(4) == 0) ? int'($urandom_range(1, 2)) : 0);
        end
    endtask

    task automatic clearProducers();
        for (int i = 0; i < NUM_REQ; i++) begin
            pq[i].delete();
            pres[i] = 1'b0;
        end
    endtask

    task automatic clearLog();
        log_q.delete();
        log_cyc.delete();
    endtask

    task automatic modelUpdate(input bit g_ok);
        bit     took, stored, was_empty, found;
        obeat_t b;
        if (!rst_n) begin
            m_owner  = -1;
            m_ptr    = 0;
            m_acc    = 1'b1;
            m_q.delete();
            model_ok = 1'b1;
            return;
        end
        took      = g_ok && m_acc;
        stored    = took && !out_rdy;
        was_empty = (m_q.size() == 0);
        if (!m_acc && out_rdy && m_q.size() > 0) begin
            void'(m_q.pop_front());
        end
        if (stored) begin
            b.data = in_data[m_owner*WD +: WD];
            b.last = in_last[m_owner];
            b.id   = m_owner;
            m_q.push_back(b);
        end
        m_acc = out_rdy || (was_empty && !stored);
        if (m_owner < 0) begin
            found = 1'b0;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!found && in_val[(m_ptr + k) % NUM_REQ]) begin
                    m_owner = (m_ptr + k) % NUM_REQ;
                    found   = 1'b1;
                end
            end
        end else if (took && in_last[m_owner]) begin
            m_ptr   = (m_owner + 1) % NUM_REQ;
            m_owner = -1;
        end
    endtask

    task automatic stepCycle();
        logic [NUM_REQ-1:0] exp_rdy;
        bit                 exp_val, g_ok;
        obeat_t             exp_b, ob;
        beat_t              hb;
        @(negedge clk);
        rst_n = !rst_req;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pres[i] && pq[i].size() > 0) begin
                hb = pq[i][0];
                if (hb.gap > 0) begin
                    hb.gap--;
                    pq[i][0] = hb;
                end else begin
                    pres[i] = 1'b1;
                end
            end
            in_val[i] = pres[i];
            if (pres[i]) begin
                in_data[i*WD +: WD] = pq[i][0].data;
                in_last[i]          = pq[i][0].last;
            end else begin
                in_data[i*WD +: WD] = WD'($urandom_range(15));
                in_last[i]          = 1'($urandom_range(1));
            end
        end
        out_rdy = rand_ordy ? ($urandom_range(99) < 70) : ordy_fixed;
        #1;
        cyc++;

        exp_rdy = '0;
        if (m_owner >= 0 && m_acc) exp_rdy[m_owner] = 1'b1;
        g_ok  = (m_owner >= 0) && in_val[m_owner];
        exp_b = '{data: '0, last: 1'b0, id: 0};
        if (m_acc) begin
            exp_val = g_ok;
            if (g_ok) begin
                exp_b.data = in_data[m_owner*WD +: WD];
                exp_b.last = in_last[m_owner];
                exp_b.id   = m_owner;
            end
        end else begin
            exp_val = (m_q.size() > 0);
            if (exp_val) exp_b = m_q[0];
        end
        if (model_ok) begin
            checkOutput("in_rdy", 32'(in_rdy), 32'(exp_rdy));
            checkOutput("out_val", 32'(out_val), 32'(exp_val));
            if (exp_val) begin
                checkOutput("out_data", 32'(out_data), 32'(exp_b.data));
                checkOutput("out_last", 32'(out_last), 32'(exp_b.last));
                checkOutput("out_id", 32'(out_id), 32'(exp_b.id));
            end
        end

        // End-to-end scoreboard: every accepted beat leaves once, in order.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (in_val[i] && in_rdy[i]) begin
                ob.data = in_data[i*WD +: WD];
                ob.last = in_last[i];
                ob.id   = i;
                sb.push_back(ob);
                if (pres[i]) begin
                    void'(pq[i].pop_front());
                    pres[i] = 1'b0;
                end
            end
        end
        if (out_val && out_rdy) begin
            checkOutput("sb_has_beat", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                ob = sb.pop_front();
                checkOutput("sb_data", 32'(out_data), 32'(ob.data));
                checkOutput("sb_last", 32'(out_last), 32'(ob.last));
                checkOutput("sb_id", 32'(out_id), 32'(ob.id));
            end
            ob.data = out_data;
            ob.last = out_last;
            ob.id   = int'(out_id);
            log_q.push_back(ob);
            log_cyc.push_back(cyc);
        end
        if (!rst_n) sb.delete();

        cur_owner = m_owner;
        modelUpdate(g_ok);
    endtask

    task automatic applyStimulus(input int n, input bit fill);
        for (int c = 0; c < n; c++) begin
            if (fill) begin
                for (int r = 0; r < NUM_REQ; r++) begin
                    if (pq[r].size() < 3 && $urandom_range(3) == 0) addRandomPacket(r);
                end
            end
            stepCycle();
        end
    endtask

    task automatic doReset();
        rst_req = 1'b1;
        stepCycle();
        stepCycle();
        rst_req = 1'b0;
    endtask

    task automatic checkLog(input string tag, input int n, input int d[8], input int id[8]);
        checkOutput({tag, "_count"}, 32'(log_q.size()), 32'(n));
        for (int k = 0; k < n && k < log_q.size(); k++) begin
            checkOutput({tag, "_data"}, 32'(log_q[k].data), 32'(d[k]));
            checkOutput({tag, "_id"}, 32'(log_q[k].id), 32'(id[k]));
        end
    endtask

    initial begin
        int pending;

        // Reset with every requester asking, then the first grant.
        clearProducers();
        for (int r = 0; r < NUM_REQ; r++) addBeat(r, r + 1, 1'b1, 0);
        ordy_fixed = 1'b1;
        rst_req    = 1'b1;
        stepCycle();
        stepCycle();
        checkOutput("rst_in_rdy", 32'(in_rdy), 32'd0);
        checkOutput("rst_out_val", 32'(out_val), 32'd0);
        checkOutput("rst_out_id", 32'(out_id), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        rst_req = 1'b0;
        stepCycle();
        checkOutput("arb_cycle_in_rdy", 32'(in_rdy), 32'd0);
        stepCycle();
        checkOutput("first_grant_in_rdy", 32'(in_rdy), 32'b0001);
        checkOutput("first_grant_out_id", 32'(out_id), 32'd0);

        // Round robin over single-beat packets.
        clearProducers();
        for (int r = 0; r < NUM_REQ; r++) addBeat(r, 8 + r, 1'b1, 0);
        addBeat(0, 12, 1'b1, 0);
        doReset();
        clearLog();
        applyStimulus(10, 1'b0);
        checkLog("rr", 5, '{8, 9, 10, 11, 12, 0, 0, 0}, '{0, 1, 2, 3, 0, 0, 0, 0});
        for (int k = 1; k < 5 && k < log_cyc.size(); k++) begin
            checkOutput("rr_bubble", 32'(log_cyc[k] - log_cyc[k-1]), 32'd2);
        end

        // Packet atomicity.
        clearProducers();
        addBeat(2, 5, 1'b0, 0);
        addBeat(2, 6, 1'b0, 0);
        addBeat(2, 7, 1'b1, 0);
        addBeat(3, 9, 1'b1, 0);
        doReset();
        clearLog();
        applyStimulus(10, 1'b0);
        checkLog("atomic", 4, '{5, 6, 7, 9, 0, 0, 0, 0}, '{2, 2, 2, 3, 0, 0, 0, 0});

        // Backpressure with one beat parked in the skid stage.
        clearProducers();
        addBeat(1, 10, 1'b0, 0);
        addBeat(1, 11, 1'b1, 0);
        doReset();
        clearLog();
        ordy_fixed = 1'b1;
        stepCycle();
        ordy_fixed = 1'b0;
        stepCycle();
        checkOutput("bp_store_in_rdy", 32'(in_rdy), 32'b0010);
        checkOutput("bp_store_out_data", 32'(out_data), 32'd10);
        for (int c = 0; c < 3; c++) begin
            stepCycle();
            checkOutput("bp_hold_in_rdy", 32'(in_rdy), 32'd0);
            checkOutput("bp_hold_out_val", 32'(out_val), 32'd1);
            checkOutput("bp_hold_out_data", 32'(out_data), 32'd10);
        end
        ordy_fixed = 1'b1;
        applyStimulus(4, 1'b0);
        checkLog("bp", 2, '{10, 11, 0, 0, 0, 0, 0, 0}, '{1, 1, 0, 0, 0, 0, 0, 0});

        // Pointer wrap from 3 and an in_val gap inside a locked packet.
        clearProducers();
        addBeat(2, 2, 1'b1, 0);
        doReset();
        applyStimulus(3, 1'b0);
        addBeat(3, 3, 1'b0, 0);
        addBeat(3, 4, 1'b1, 2);
        addBeat(1, 13, 1'b1, 0);
        addBeat(0, 14, 1'b1, 0);
        clearLog();
        for (int c = 0; c < 10; c++) begin
            stepCycle();
            if (cur_owner == 3) checkOutput("gap_in_rdy1", 32'(in_rdy[1]), 32'd0);
        end
        checkLog("wrap", 4, '{3, 4, 14, 13, 0, 0, 0, 0}, '{3, 3, 0, 1, 0, 0, 0, 0});

        // Reset while a beat sits in the skid buffer.
        clearProducers();
        addBeat(0, 6, 1'b0, 0);
        addBeat(0, 7, 1'b0, 0);
        addBeat(0, 15, 1'b1, 0);
        doReset();
        ordy_fixed = 1'b1;
        stepCycle();
        ordy_fixed = 1'b0;
        stepCycle();
        stepCycle();
        checkOutput("mid_buf_out_val", 32'(out_val), 32'd1);
        checkOutput("mid_buf_out_data", 32'(out_data), 32'd6);
        rst_req = 1'b1;
        stepCycle();
        rst_req = 1'b0;
        clearProducers();
        ordy_fixed = 1'b1;
        clearLog();
        stepCycle();
        checkOutput("mid_rst_out_val", 32'(out_val), 32'd0);
        checkOutput("mid_rst_in_rdy", 32'(in_rdy), 32'd0);
        addBeat(1, 1, 1'b1, 0);
        applyStimulus(4, 1'b0);
        checkLog("mid_rst", 1, '{1, 0, 0, 0, 0, 0, 0, 0}, '{1, 0, 0, 0, 0, 0, 0, 0});

        // Random traffic with random backpressure, then a bounded drain.
        clearProducers();
        doReset();
        rand_ordy = 1'b1;
        applyStimulus(1500, 1'b1);
        rand_ordy  = 1'b0;
        ordy_fixed = 1'b1;
        for (int c = 0; c < 400; c++) begin
            pending = sb.size();
            for (int r = 0; r < NUM_REQ; r++) pending += pq[r].size();
            if (pending != 0) stepCycle();
        end
        pending = sb.size();
        for (int r = 0; r < NUM_REQ; r++) pending += pq[r].size();
        checkOutput("drain_pending", 32'(pending), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
